// File: rtl/led_pkg.sv
// Shared types and brightness scaling for the LED frame streamer.
package led_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_STREAM,
    ST_DRAIN
  } state_t;

  // Scaling by (bri+1) makes 255 an exact identity and 0 a hard black.
  function automatic logic [7:0] scale_channel(input logic [7:0] c, input logic [7:0] bri);
    logic [16:0] prod;
    prod = {9'd0, c} * ({9'd0, bri} + 17'd1);
    return 8'(prod >> 8);
  endfunction

  function automatic rgb_t scale_pixel(input rgb_t px, input logic [7:0] bri);
    rgb_t o;
    o.r = scale_channel(px.r, bri);
    o.g = scale_channel(px.g, bri);
    o.b = scale_channel(px.b, bri);
    return o;
  endfunction

endpackage

// File: rtl/led_pixel_ram.sv
// Two-bank pixel store: writes go to one bank, reads come from the other,
// with a registered read port.
module led_pixel_ram
  import led_pkg::*;
#(
  parameter int NUM_LEDS = 64,
  localparam int ADDR_W = $clog2(NUM_LEDS)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  rgb_t              wr_data,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output rgb_t              rd_data
);

  localparam int DEPTH  = 2 * NUM_LEDS;
  localparam int RAM_AW = $clog2(DEPTH);

  rgb_t mem [DEPTH];

  function automatic logic [RAM_AW-1:0] flat(input logic bank, input logic [ADDR_W-1:0] a);
    return bank ? RAM_AW'(NUM_LEDS) + RAM_AW'(a) : RAM_AW'(a);
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en) mem[flat(wr_bank, wr_addr)] <= wr_data;
    rd_data <= mem[flat(rd_bank, rd_addr)];
  end

endmodule

// File: rtl/led_frame_streamer.sv
// Double-buffered frame store that streams brightness-scaled pixels into the
// WS2812B driver handshake on commit or auto-refresh.
module led_frame_streamer
  import led_pkg::*;
#(
  parameter int NUM_LEDS       = 64,
  parameter int REFRESH_CYCLES = 0,
  localparam int ADDR_W = $clog2(NUM_LEDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              commit,
  input  logic [7:0]        brightness,
  output logic              commit_pending,
  output logic              frame_active,
  output logic              frame_done,
  output logic              drv_ready,
  output logic [23:0]       drv_rgb,
  input  logic              drv_busy,
  input  logic              drv_latched
);

  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LEDS - 1);

  state_t            state, next_state;
  logic              front;
  logic [CNT_W-1:0]  idle_cnt;
  logic [ADDR_W-1:0] pix_idx;
  logic [7:0]        bri_q;
  logic              fetch_ph;
  rgb_t              rd_data;

  logic wr_ok, refresh_hit, start, swap, advance, last, drain_done;

  assign wr_ok       = wr_en && ({1'b0, wr_addr} < NUM_LEDS[ADDR_W:0]);
  assign refresh_hit = (REFRESH_CYCLES != 0) && (idle_cnt == CNT_W'(REFRESH_CYCLES - 1));

  led_pixel_ram #(.NUM_LEDS(NUM_LEDS)) u_ram (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_bank (~front),
    .wr_addr (wr_addr),
    .wr_data (rgb_t'(wr_data)),
    .rd_bank (front),
    .rd_addr (pix_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    swap       = 1'b0;
    advance    = 1'b0;
    last       = 1'b0;
    drain_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (commit_pending) begin
          swap       = 1'b1;
          start      = 1'b1;
          next_state = ST_FETCH;
        end else if (refresh_hit) begin
          start      = 1'b1;
          next_state = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (fetch_ph) next_state = ST_STREAM;
      end
      ST_STREAM: begin
        if (drv_latched) begin
          if (pix_idx == LAST_IDX) begin
            last       = 1'b1;
            next_state = ST_DRAIN;
          end else begin
            advance    = 1'b1;
            next_state = ST_FETCH;
          end
        end
      end
      ST_DRAIN: begin
        if (!drv_busy) begin
          drain_done = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // FETCH takes two cycles: RAM read, then the registered scale into drv_rgb.
  always_ff @(posedge clk) begin
    if (rst) begin
      front          <= 1'b0;
      commit_pending <= 1'b0;
      idle_cnt       <= '0;
      pix_idx        <= '0;
      bri_q          <= '0;
      fetch_ph       <= 1'b0;
      frame_active   <= 1'b0;
      frame_done     <= 1'b0;
      drv_ready      <= 1'b0;
      drv_rgb        <= '0;
    end else begin
      if (swap) front <= ~front;

      if (swap)        commit_pending <= 1'b0;
      else if (commit) commit_pending <= 1'b1;

      if (start)                 idle_cnt <= '0;
      else if (state == ST_IDLE) idle_cnt <= idle_cnt + CNT_W'(1);

      if (start) begin
        pix_idx      <= '0;
        bri_q        <= brightness;
        frame_active <= 1'b1;
      end else if (advance) begin
        pix_idx <= pix_idx + ADDR_W'(1);
      end

      fetch_ph <= (state == ST_FETCH) ? ~fetch_ph : 1'b0;

      if (state == ST_FETCH && fetch_ph) begin
        drv_rgb   <= scale_pixel(rd_data, bri_q);
        drv_ready <= 1'b1;
      end else if (last) begin
        drv_ready <= 1'b0;
      end

      frame_done <= drain_done;
      if (drain_done) frame_active <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_frame_streamer.sv
// Scoreboard bench: a frame-level reference model predicts every transmitted
// pixel and the control outputs; a behavioural driver answers the handshake.
module tb_led_frame_streamer;

  localparam int N  = 5;
  localparam int R  = 100;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst, wr_en, commit;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic [7:0]    brightness;
  logic          commit_pending, frame_active, frame_done, drv_ready;
  logic [23:0]   drv_rgb;
  logic          drv_busy, drv_latched;

  always #5 clk = ~clk;

  led_frame_streamer #(.NUM_LEDS(N), .REFRESH_CYCLES(R)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .brightness(brightness), .commit_pending(commit_pending),
    .frame_active(frame_active), .frame_done(frame_done), .drv_ready(drv_ready),
    .drv_rgb(drv_rgb), .drv_busy(drv_busy), .drv_latched(drv_latched)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] ref_scale(input logic [23:0] p, input int b);
    int r, g, bl;
    r  = int'(p[23:16]) * (b + 1) / 256;
    g  = int'(p[15:8])  * (b + 1) / 256;
    bl = int'(p[7:0])   * (b + 1) / 256;
    return {r[7:0], g[7:0], bl[7:0]};
  endfunction

  // Reference model: two banks, a front pointer and the frame-level rules.
  logic [23:0] m_mem [2][N];
  logic [23:0] exp_q [$];
  bit m_front, m_pend, m_busy, m_drain, m_done, model_on;
  int m_cnt, m_lat;

  always @(posedge clk) begin
    automatic bit start = 0;
    automatic bit swap = 0;
    model_on = 1;
    if (rst) begin
      m_front = 0; m_pend = 0; m_busy = 0; m_drain = 0; m_done = 0;
      m_cnt = 0; m_lat = 0;
      exp_q.delete();
    end else begin
      m_done = 0;
      if (wr_en && int'(wr_addr) < N) m_mem[!m_front][wr_addr] = wr_data;
      if (!m_busy) begin
        if (m_pend) begin swap = 1; start = 1; end
        else if (m_cnt == R - 1) start = 1;
        else m_cnt++;
      end else if (m_drain) begin
        if (!drv_busy) begin m_busy = 0; m_drain = 0; m_done = 1; end
      end else if (drv_latched) begin
        m_lat++;
        if (m_lat == N) m_drain = 1;
      end
      if (swap) begin m_front = !m_front; m_pend = 0; end
      else if (commit) m_pend = 1;
      if (start) begin
        m_busy = 1; m_lat = 0; m_cnt = 0;
        for (int i = 0; i < N; i++) exp_q.push_back(ref_scale(m_mem[m_front][i], int'(brightness)));
      end
    end
  end

  // Monitor: each driver latch consumes one expected pixel.
  always @(posedge clk) begin
    automatic logic lat = drv_latched;
    automatic logic rs = rst;
    #1;
    if (!rs && lat) begin
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_pixel: got 0x%0h, expected none at %0t", drv_rgb, $time);
      end else begin
        chk("drv_rgb", 32'(drv_rgb), 32'(exp_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("frame_active", 32'(frame_active), 32'(m_busy));
      chk("commit_pending", 32'(commit_pending), 32'(m_pend));
      chk("frame_done", 32'(frame_done), 32'(m_done));
      if (!m_busy || m_drain) chk("drv_ready_low", 32'(drv_ready), 32'd0);
    end
  end

  // Behavioural WS2812B driver: latch when ready, stay busy for a bit period.
  initial begin
    int gap;
    gap = 0; drv_busy = 0; drv_latched = 0;
    forever begin
      @(negedge clk);
      drv_latched = 0;
      if (rst) begin drv_busy = 0; gap = 0; end
      else if (gap > 0) gap--;
      else if (drv_ready) begin
        drv_latched = 1; drv_busy = 1; gap = int'($urandom_range(3, 9));
      end else drv_busy = 0;
    end
  end

  task automatic write_px(input int a, input logic [23:0] d);
    @(negedge clk);
    wr_en = 1; wr_addr = AW'(a); wr_data = d;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic do_commit();
    @(negedge clk);
    commit = 1;
    @(negedge clk);
    commit = 0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) write_px(i, 24'($urandom));
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((m_busy || m_pend) && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) begin
      vectors++; miscompares++;
      $display("FAIL wait_idle_timeout: got busy, expected idle at %0t", $time);
    end
  endtask

  task automatic wait_latched(input int n);
    int t = 0;
    while (!(m_busy && !m_drain && m_lat >= n) && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) begin
      vectors++; miscompares++;
      $display("FAIL wait_latch_timeout: got %0d latches, expected %0d at %0t", m_lat, n, $time);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1; wr_en = 0; wr_addr = '0; wr_data = '0; commit = 0; brightness = 8'd255;
    repeat (3) @(negedge clk);
    rst = 0;

    // Directed colours at full brightness.
    write_px(0, 24'h110000); write_px(1, 24'h002200); write_px(2, 24'h000033);
    write_px(3, 24'hFFFFFF); write_px(4, 24'hFF8040);
    do_commit();
    wait_idle();

    // Half brightness; a brightness change mid-frame must not apply.
    fill_random();
    write_px(0, 24'hFF8040);
    brightness = 8'd127;
    do_commit();
    wait_latched(1);
    brightness = 8'd3;
    write_px(0, 24'h123456);
    wait_idle();

    // Zero brightness on white.
    for (int i = 0; i < N; i++) write_px(i, 24'hFFFFFF);
    brightness = 8'd0;
    do_commit();
    wait_idle();

    // Out-of-range writes leave the bank untouched.
    brightness = 8'd255;
    fill_random();
    write_px(N, 24'hDEAD01);
    write_px(7, 24'hDEAD02);
    do_commit();
    wait_idle();

    // Commit during streaming is deferred until after frame_done.
    fill_random();
    do_commit();
    wait_latched(2);
    fill_random();
    do_commit();
    wait_idle();

    // Auto-refresh with no commit.
    t = 0;
    while (!m_busy && t < 200) begin @(negedge clk); t++; end
    chk("refresh_started", 32'(m_busy), 32'd1);
    wait_idle();

    // Commit arriving so pending coincides with refresh expiry.
    fill_random();
    t = 0;
    while (!(!m_busy && !m_pend && m_cnt == R - 2) && t < 300) begin @(negedge clk); t++; end
    chk("refresh_align", 32'(m_cnt), 32'(R - 2));
    commit = 1;
    @(negedge clk);
    commit = 0;
    wait_idle();

    // Reset in the middle of a frame, with a commit pending.
    fill_random();
    do_commit();
    wait_latched(2);
    commit = 1;
    @(negedge clk);
    commit = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_drv_ready", 32'(drv_ready), 32'd0);
    fill_random();
    do_commit();
    wait_idle();

    // Randomized traffic.
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: repeat ($urandom_range(1, 6)) write_px(int'($urandom_range(0, 7)), 24'($urandom));
        1: do_commit();
        2: begin @(negedge clk); brightness = 8'($urandom); end
        default: repeat ($urandom_range(0, 130)) @(negedge clk);
      endcase
    end
    wait_idle();
    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_frame_streamer.md
Name: led_frame_streamer

Overview:
Upstream feeder for the WS2812B serial driver `led_driver`. It holds a double-buffered frame of NUM_LEDS 24-bit RGB pixels, written by display/CPU logic. On commit or auto-refresh it streams the front buffer pixel-by-pixel into the driver's ready/rgb_data/data_latched handshake, applying global brightness scaling. It drops drv_ready after the last pixel so the driver emits its reset/latch pulse.

Parameters:
NUM_LEDS, 64, LEDs in chain (>=2); localparam ADDR_W = $clog2(NUM_LEDS)
REFRESH_CYCLES, 0, idle cycles before automatic retransmit of front buffer; 0 disables auto-refresh

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
wr_en  in  1  write strobe into back buffer
wr_addr  in  ADDR_W  pixel index; values >= NUM_LEDS ignored
wr_data  in  24  pixel {R,G,B}
commit  in  1  one-cycle request: swap buffers and transmit
brightness  in  8  global scale, sampled at frame start
commit_pending  out  1  commit accepted, swap not yet done
frame_active  out  1  high from frame start until frame_done
frame_done  out  1  one-cycle pulse when driver returns idle after frame
drv_ready  out  1  to driver ready
drv_rgb  out  24  to driver rgb_data, scaled {R,G,B} (driver does GRB reorder)
drv_busy  in  1  from driver busy
drv_latched  in  1  from driver data_latched

Behaviour:
- Reset values: all outputs 0; front bank = 0; pending cleared; idle counter 0; FSM IDLE. RAM contents not cleared. Reset mid-frame aborts immediately (drv_ready 0 next cycle).
- Writes: any cycle, any state, always to back bank; 1-cycle write. Same-cycle write and swap: write lands in the pre-swap back bank.
- commit sets commit_pending (sticky). Commit while pending = no-op.
- States: IDLE, FETCH, STREAM, DRAIN.
- IDLE: if commit_pending: swap banks, clear pending, start frame. Else if REFRESH_CYCLES!=0 and idle counter == REFRESH_CYCLES-1: start frame, no swap. Commit wins over refresh in the same cycle. Idle counter counts only in IDLE and clears on frame start.
- Frame start: pix_idx=0, latch brightness into bri_q, frame_active=1, go to FETCH.
- FETCH: RAM read at pix_idx has 1-cycle latency. Scale is registered. drv_rgb valid 2 cycles after FETCH entry. Then drv_ready=1 and go to STREAM.
- Scaling per channel: out = (c * (bri_q+1)) >> 8, using a 8x9 -> 17-bit product and taking bits [15:8]. bri_q=255 is identity; bri_q=0 gives 0 (not 1/256).
- STREAM: drv_rgb is held stable until drv_latched.
  - On drv_latched with pix_idx < NUM_LEDS-1: pix_idx++, re-enter FETCH with drv_ready kept high. The new drv_rgb is valid within 3 cycles, well before the next driver latch (24 bit times later).
  - On drv_latched with pix_idx == NUM_LEDS-1: drv_ready=0 next cycle, go to DRAIN.
  - drv_latched in any other state is ignored.
- DRAIN: wait for drv_busy==0, meaning the driver's reset pulse has completed. Then pulse frame_done, set frame_active=0, go to IDLE.
- Commit during a frame is deferred until the next IDLE; the frame in flight is never altered.
- Swap leaves the new back bank holding the older frame; the writer must rewrite every pixel it cares about.
- drv_ready is only high in FETCH/STREAM of an active frame. It is never high in IDLE or DRAIN.

Decomposition:
- Package led_pkg: rgb_t (packed struct r,g,b 8b each), streamer state enum, scale_channel function.
- Sub-module led_pixel_ram: dual-bank simple dual-port RAM (2*NUM_LEDS x 24). Write port selects the back bank; read port selects the front bank; 1-cycle registered read.

Test Plan:
- NUM_LEDS=4, brightness=255, write 0x110000,0x002200,0x000033,0xFFFFFF, commit; pair with real led_driver (CLK_FREQ small) -> drv_rgb presents the 4 values in order, one per drv_latched, drv_ready falls after 4th latched, frame_done pulses once after driver busy drops.
- brightness=127, pixel 0xFF8040 -> drv_rgb=0x7F4020; brightness=0, pixel 0xFFFFFF -> 0x000000; brightness change mid-frame -> no effect until next frame.
- commit asserted during STREAM -> commit_pending=1, current frame unchanged, new frame starts after frame_done with swapped bank contents.
- REFRESH_CYCLES=100, no commits -> frame restarts exactly 100 idle cycles after frame_done, same front data; commit and refresh expiry in the same cycle -> swap occurs.
- wr_addr=NUM_LEDS with wr_en -> no RAM change; write during streaming -> front data transmitted unaffected.
- rst asserted mid-STREAM -> next cycle drv_ready=0, frame_active=0, commit_pending=0; following commit transmits correctly.
